// File: rtl/chr_bg_ctrl_pkg.sv
// rtl/chr_bg_ctrl_pkg.sv - shared constants, register codes and fill states for chr_bg_ctrl
package chr_bg_ctrl_pkg;

  localparam int MAP_BITS  = 6;
  localparam int ADDR_BITS = 2 * MAP_BITS;
  localparam int DIM_BITS  = MAP_BITS + 1;
  localparam int MAP_CELLS = 1 << MAP_BITS;
  localparam int NUM_REGS  = 8;

  localparam logic [2:0] REG_SEL_X     = 3'd0;
  localparam logic [2:0] REG_SEL_Y     = 3'd1;
  localparam logic [2:0] REG_SEL_SCALE = 3'd2;
  localparam logic [2:0] REG_SEL_PAL0  = 3'd3;
  localparam logic [2:0] REG_SEL_PAL1  = 3'd4;
  localparam logic [2:0] REG_SEL_PAL2  = 3'd5;
  localparam logic [2:0] REG_SEL_PAL3  = 3'd6;
  localparam logic [2:0] REG_SEL_NONE  = 3'd7;

  typedef enum logic [1:0] {
    FILL_IDLE = 2'd0,
    FILL_RUN  = 2'd1,
    FILL_DONE = 2'd2
  } fill_state_e;

  // Rectangle dimensions above the map size saturate to a full map span.
  function automatic logic [DIM_BITS-1:0] clamp_dim(input logic [DIM_BITS-1:0] d);
    if (d > DIM_BITS'(MAP_CELLS)) return DIM_BITS'(MAP_CELLS);
    return d;
  endfunction

endpackage

// File: rtl/chr_bg_ctrl_if.sv
// rtl/chr_bg_ctrl_if.sv - CPU, fill, config and name-table port bundle for chr_bg_ctrl
interface chr_bg_ctrl_if;
  import chr_bg_ctrl_pkg::*;

  logic                 cpu_req;
  logic [ADDR_BITS-1:0] cpu_addr;
  logic [7:0]           cpu_data;
  logic                 cpu_ack;

  logic                 fill_start;
  logic [MAP_BITS-1:0]  fill_col;
  logic [MAP_BITS-1:0]  fill_row;
  logic [DIM_BITS-1:0]  fill_w;
  logic [DIM_BITS-1:0]  fill_h;
  logic [7:0]           fill_value;
  logic                 fill_busy;
  logic                 fill_done;

  logic                 reg_we;
  logic [2:0]           reg_sel;
  logic [31:0]          reg_wdata;
  logic                 vblank;

  logic [31:0]          chr_address;
  logic [7:0]           chr_din;
  logic                 chr_we;
  logic [31:0]          x, y, scale;
  logic [31:0]          palette0, palette1, palette2, palette3;

  modport master (
    output cpu_req, cpu_addr, cpu_data,
    output fill_start, fill_col, fill_row, fill_w, fill_h, fill_value,
    output reg_we, reg_sel, reg_wdata, vblank,
    input  cpu_ack, fill_busy, fill_done,
    input  chr_address, chr_din, chr_we,
    input  x, y, scale, palette0, palette1, palette2, palette3
  );

  modport slave (
    input  cpu_req, cpu_addr, cpu_data,
    input  fill_start, fill_col, fill_row, fill_w, fill_h, fill_value,
    input  reg_we, reg_sel, reg_wdata, vblank,
    output cpu_ack, fill_busy, fill_done,
    output chr_address, chr_din, chr_we,
    output x, y, scale, palette0, palette1, palette2, palette3
  );

endinterface

// File: rtl/chr_bg_ctrl_fill_engine.sv
// rtl/chr_bg_ctrl_fill_engine.sv - rectangle-fill FSM walking cells row-major with toroidal wrap
module chr_bg_ctrl_fill_engine
  import chr_bg_ctrl_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [MAP_BITS-1:0]  i_col,
  input  logic [MAP_BITS-1:0]  i_row,
  input  logic [DIM_BITS-1:0]  i_w,
  input  logic [DIM_BITS-1:0]  i_h,
  input  logic [7:0]           i_value,
  input  logic                 i_grant,
  output logic                 o_req,
  output logic [ADDR_BITS-1:0] o_addr,
  output logic [7:0]           o_data,
  output logic                 o_busy,
  output logic                 o_done
);

  fill_state_e          r_state, w_state_nxt;
  logic [MAP_BITS-1:0]  r_col, r_row, r_c, r_r;
  logic [DIM_BITS-1:0]  r_w, r_h;
  logic [7:0]           r_value;
  logic [DIM_BITS-1:0]  w_w_clamped, w_h_clamped;
  logic                 w_last_col, w_last_row;

  assign w_w_clamped = clamp_dim(i_w);
  assign w_h_clamped = clamp_dim(i_h);
  assign w_last_col  = ({1'b0, r_c} == r_w - DIM_BITS'(1));
  assign w_last_row  = ({1'b0, r_r} == r_h - DIM_BITS'(1));

  // Six-bit sums wrap naturally, giving the mod-64 map wrap for free.
  assign o_addr = {r_row + r_r, r_col + r_c};
  assign o_data = r_value;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= FILL_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_col   <= '0;
      r_row   <= '0;
      r_c     <= '0;
      r_r     <= '0;
      r_w     <= '0;
      r_h     <= '0;
      r_value <= '0;
    end else if (r_state == FILL_IDLE && i_start) begin
      r_col   <= i_col;
      r_row   <= i_row;
      r_c     <= '0;
      r_r     <= '0;
      r_w     <= w_w_clamped;
      r_h     <= w_h_clamped;
      r_value <= i_value;
    end else if (r_state == FILL_RUN && i_grant) begin
      if (w_last_col) begin
        r_c <= '0;
        r_r <= r_r + MAP_BITS'(1);
      end else begin
        r_c <= r_c + MAP_BITS'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_req       = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      FILL_IDLE: begin
        if (i_start)
          w_state_nxt = (w_w_clamped != '0 && w_h_clamped != '0) ? FILL_RUN : FILL_DONE;
      end
      FILL_RUN: begin
        o_req  = 1'b1;
        o_busy = 1'b1;
        if (i_grant && w_last_col && w_last_row) w_state_nxt = FILL_DONE;
      end
      FILL_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = FILL_IDLE;
      end
      default: w_state_nxt = FILL_IDLE;
    endcase
  end

endmodule

// File: rtl/chr_bg_ctrl.sv
// rtl/chr_bg_ctrl.sv - character layer front end: write-port arbiter, fill engine, config registers
// Optional CHR_BG_CTRL_SHADOW_EN: config writes are held pending and committed together on vblank.
module chr_bg_ctrl
  import chr_bg_ctrl_pkg::*;
#(
  parameter logic [31:0] SCALE_INIT = 32'd8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  chr_bg_ctrl_if.slave  bus
);

  logic                 w_fill_req, w_fill_busy, w_fill_done;
  logic [ADDR_BITS-1:0] w_fill_addr;
  logic [7:0]           w_fill_data;
  logic                 w_cpu_pend, w_grant_cpu, w_grant_fill;
  logic                 r_chr_we, r_cpu_ack, r_last_cpu;
  logic [ADDR_BITS-1:0] r_chr_addr;
  logic [7:0]           r_chr_din;
  logic [31:0]          r_cfg [NUM_REGS];
  logic                 w_reg_wr;

  chr_bg_ctrl_fill_engine u_fill (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (bus.fill_start),
    .i_col   (bus.fill_col),
    .i_row   (bus.fill_row),
    .i_w     (bus.fill_w),
    .i_h     (bus.fill_h),
    .i_value (bus.fill_value),
    .i_grant (w_grant_fill),
    .o_req   (w_fill_req),
    .o_addr  (w_fill_addr),
    .o_data  (w_fill_data),
    .o_busy  (w_fill_busy),
    .o_done  (w_fill_done)
  );

  // A request still held while its ack is visible has already been served.
  assign w_cpu_pend   = bus.cpu_req & ~r_cpu_ack;
  assign w_grant_cpu  = w_cpu_pend & (~w_fill_req | ~r_last_cpu);
  assign w_grant_fill = w_fill_req & ~w_grant_cpu;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_chr_we   <= 1'b0;
      r_cpu_ack  <= 1'b0;
      r_chr_addr <= '0;
      r_chr_din  <= '0;
      r_last_cpu <= 1'b1;
    end else begin
      r_chr_we  <= w_grant_cpu | w_grant_fill;
      r_cpu_ack <= w_grant_cpu;
      if (w_grant_cpu) begin
        r_chr_addr <= bus.cpu_addr;
        r_chr_din  <= bus.cpu_data;
      end else if (w_grant_fill) begin
        r_chr_addr <= w_fill_addr;
        r_chr_din  <= w_fill_data;
      end
      if (w_grant_cpu | w_grant_fill) r_last_cpu <= w_grant_cpu;
    end
  end

  assign bus.chr_we      = r_chr_we;
  assign bus.cpu_ack     = r_cpu_ack;
  assign bus.chr_address = {{(32-ADDR_BITS){1'b0}}, r_chr_addr};
  assign bus.chr_din     = r_chr_din;
  assign bus.fill_busy   = w_fill_busy;
  assign bus.fill_done   = w_fill_done;

  function automatic logic [31:0] cfg_reset(input int idx);
    return (idx == int'(REG_SEL_SCALE)) ? SCALE_INIT : 32'd0;
  endfunction

  assign w_reg_wr = bus.reg_we && (bus.reg_sel != REG_SEL_NONE);

`ifdef CHR_BG_CTRL_SHADOW_EN
  logic [31:0] r_pend     [NUM_REGS];
  logic [31:0] w_pend_nxt [NUM_REGS];

  // The pending image already includes this cycle's write, so a coincident vblank commits it.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) w_pend_nxt[i] = r_pend[i];
    if (w_reg_wr) w_pend_nxt[bus.reg_sel] = bus.reg_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_pend[i] <= cfg_reset(i);
        r_cfg[i]  <= cfg_reset(i);
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) r_pend[i] <= w_pend_nxt[i];
      if (bus.vblank)
        for (int i = 0; i < NUM_REGS; i++) r_cfg[i] <= w_pend_nxt[i];
    end
  end
`else
  logic w_unused_vblank;
  assign w_unused_vblank = bus.vblank;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_cfg[i] <= cfg_reset(i);
    end else if (w_reg_wr) begin
      r_cfg[bus.reg_sel] <= bus.reg_wdata;
    end
  end
`endif

  assign bus.x        = r_cfg[REG_SEL_X];
  assign bus.y        = r_cfg[REG_SEL_Y];
  assign bus.scale    = r_cfg[REG_SEL_SCALE];
  assign bus.palette0 = r_cfg[REG_SEL_PAL0];
  assign bus.palette1 = r_cfg[REG_SEL_PAL1];
  assign bus.palette2 = r_cfg[REG_SEL_PAL2];
  assign bus.palette3 = r_cfg[REG_SEL_PAL3];

endmodule
